k005297_z14seq: RTL and testbench

// - Sequencer for the Z14 (CRC14) lock evaluator. Runs one supplementary-loop acquisition: slot-0 arm,
//   ACQ/DLCNT start, LOOP_BITS shift strobes, SUPBD end, then checks the zero-syndrome flag.
// - Retries up to MAX_RETRY times. Reports LOCKED/FAIL and drops lock on timer-25K timeover.
// - Sits between the bubble-controller command FSM and the Z14 evaluator. Drives that evaluator's start/shift/end/error inputs.

---
 rtl/k005297_z14seq.sv | 196 +++++++++++++++++++
 tb/tb_k005297_z14seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k005297_z14seq.sv
// Z14 (CRC14) lock-acquisition sequencer: arms on slot-0, shifts one supplementary loop, checks the syndrome, retries.
// Optional watchdog on a starved SHIFT phase is enabled by defining K005297_Z14SEQ_WDT_EN.
module k005297_z14seq #(
    parameter int LOOP_BITS = 584,
    parameter int MAX_RETRY = 3,
    parameter int WDT_TICKS = 1024
) (
    input  logic       i_MCLK,
    input  logic       i_SYS_RST,
    input  logic       i_CLK2M_PCEN_n,
    input  logic       i_ROT20_n0,
    input  logic       i_LOCK_REQ,
    input  logic       i_BIT_VALID,
    input  logic       i_Z14_n,
    input  logic       i_TIMEOVER_n,
    output logic       o_ACQ_START,
    output logic       o_DLCNT_START_n,
    output logic       o_SUPBDLCNTR_CNT,
    output logic       o_SUPBD_END_n,
    output logic       o_Z14_ERR_n,
    output logic       o_LOCKED,
    output logic       o_LOCK_FAIL,
    output logic [1:0] o_RETRY_CNT,
    output logic       o_WDT_TRIP
);

    localparam int BW = $clog2(LOOP_BITS);
    localparam int RW = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SHIFT,
        S_SETTLE,
        S_CHECK,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t        state, state_nx;
    logic [BW-1:0] bit_cnt, bit_cnt_nx;
    logic [RW-1:0] retry_cnt, retry_cnt_nx;
    logic          acq_q, acq_nx;
    logic          dlcnt_n_q, dlcnt_n_nx;
    logic          end_n_q, end_n_nx;
    logic          err_n_q, err_n_nx;
    logic          tick;
    logic          abort;
    logic          wdt_expire;

    assign tick  = ~i_CLK2M_PCEN_n;
    assign abort = ~i_LOCK_REQ &&
                   (state inside {S_ARM, S_SHIFT, S_SETTLE, S_CHECK, S_LOCKED});

    always_ff @(posedge i_MCLK) begin
        if (i_SYS_RST) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            retry_cnt <= '0;
            acq_q     <= 1'b0;
            dlcnt_n_q <= 1'b1;
            end_n_q   <= 1'b1;
            err_n_q   <= 1'b1;
        end else if (tick) begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            retry_cnt <= retry_cnt_nx;
            acq_q     <= acq_nx;
            dlcnt_n_q <= dlcnt_n_nx;
            end_n_q   <= end_n_nx;
            err_n_q   <= err_n_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        retry_cnt_nx = retry_cnt;
        acq_nx       = 1'b0;
        dlcnt_n_nx   = 1'b1;
        end_n_nx     = 1'b1;
        err_n_nx     = 1'b1;

        case (state)
            S_IDLE: begin
                if (i_LOCK_REQ) begin
                    state_nx     = S_ARM;
                    retry_cnt_nx = '0;
                end
            end
            S_ARM: begin
                if (!i_ROT20_n0) begin
                    acq_nx     = 1'b1;
                    dlcnt_n_nx = 1'b0;
                    bit_cnt_nx = '0;
                    state_nx   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (wdt_expire) begin
                    err_n_nx = 1'b0;
                    state_nx = S_FAIL;
                end else if (i_BIT_VALID) begin
                    if (bit_cnt == BW'(LOOP_BITS - 1)) begin
                        end_n_nx = 1'b0;
                        state_nx = S_SETTLE;
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end
            end
            S_SETTLE: state_nx = S_CHECK;
            S_CHECK: begin
                if (!i_Z14_n) begin
                    state_nx = S_LOCKED;
                end else begin
                    retry_cnt_nx = retry_cnt + 1'b1;
                    if (retry_cnt_nx == RW'(MAX_RETRY)) begin
                        err_n_nx = 1'b0;
                        state_nx = S_FAIL;
                    end else begin
                        state_nx = S_ARM;
                    end
                end
            end
            S_LOCKED: begin
                if (!i_TIMEOVER_n) begin
                    err_n_nx     = 1'b0;
                    state_nx     = S_IDLE;
                    bit_cnt_nx   = '0;
                    retry_cnt_nx = '0;
                end
            end
            S_FAIL: begin
                if (!i_LOCK_REQ) begin
                    state_nx     = S_IDLE;
                    bit_cnt_nx   = '0;
                    retry_cnt_nx = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Request withdrawal overrides everything; only a held lock is told to drop via ERR.
        if (abort) begin
            state_nx     = S_IDLE;
            bit_cnt_nx   = '0;
            retry_cnt_nx = '0;
            acq_nx       = 1'b0;
            dlcnt_n_nx   = 1'b1;
            end_n_nx     = 1'b1;
            err_n_nx     = (state == S_LOCKED) ? 1'b0 : 1'b1;
        end
    end

`ifdef K005297_Z14SEQ_WDT_EN
    localparam int WW = $clog2(WDT_TICKS + 1);

    logic [WW-1:0] wdt_cnt;
    logic          wdt_trip_q;

    assign wdt_expire = (state == S_SHIFT) && !i_BIT_VALID &&
                        (wdt_cnt == WW'(WDT_TICKS - 1));

    always_ff @(posedge i_MCLK) begin
        if (i_SYS_RST) begin
            wdt_cnt    <= '0;
            wdt_trip_q <= 1'b0;
        end else if (tick) begin
            if (state != S_SHIFT || i_BIT_VALID)
                wdt_cnt <= '0;
            else
                wdt_cnt <= wdt_cnt + 1'b1;
            if (state == S_IDLE && i_LOCK_REQ)
                wdt_trip_q <= 1'b0;
            else if (wdt_expire && i_LOCK_REQ)
                wdt_trip_q <= 1'b1;
        end
    end

    assign o_WDT_TRIP = wdt_trip_q;
`else
    assign wdt_expire = 1'b0;
    assign o_WDT_TRIP = 1'b0;
`endif

    assign o_ACQ_START      = acq_q;
    assign o_DLCNT_START_n  = dlcnt_n_q;
    assign o_SUPBDLCNTR_CNT = (state == S_SHIFT) && i_BIT_VALID;
    assign o_SUPBD_END_n    = end_n_q;
    assign o_Z14_ERR_n      = err_n_q;
    assign o_LOCKED         = (state == S_LOCKED);
    assign o_LOCK_FAIL      = (state == S_FAIL);
    assign o_RETRY_CNT      = (retry_cnt > RW'(3)) ? 2'd3 : retry_cnt[1:0];

endmodule

// File: tb/tb_k005297_z14seq.sv
// Self-checking bench for k005297_z14seq: random per-tick stimulus against an event-level expectation model.
// Define K005297_Z14SEQ_WDT_EN for both files to exercise the watchdog scenario.
module tb_k005297_z14seq;

    localparam int LB   = 8;
    localparam int MAXR = 3;
    localparam int WDT  = 16;
    localparam int NMAX = 256;
    localparam logic [9:0] RST_VEC = 10'b0101100000;

    logic       clk = 1'b0;
    logic       rst, pcen_n, rot_n0, req, valid, z14_n, tmo_n;
    logic       acq, dl_n, cnt, end_n, err_n, locked, fail, wdt;
    logic [1:0] retry;

    int errors = 0;
    int checks = 0;

    bit         s_req[NMAX], s_rot[NMAX], s_valid[NMAX], s_z14[NMAX], s_tmo[NMAX];
    logic [9:0] obs[NMAX];
    bit         e_acq[NMAX], e_dl[NMAX], e_cnt[NMAX], e_end[NMAX], e_err[NMAX];
    bit         e_lock[NMAX], e_fail[NMAX];
    int         e_retry[NMAX];

    k005297_z14seq #(.LOOP_BITS(LB), .MAX_RETRY(MAXR), .WDT_TICKS(WDT)) dut (
        .i_MCLK(clk), .i_SYS_RST(rst), .i_CLK2M_PCEN_n(pcen_n),
        .i_ROT20_n0(rot_n0), .i_LOCK_REQ(req), .i_BIT_VALID(valid),
        .i_Z14_n(z14_n), .i_TIMEOVER_n(tmo_n),
        .o_ACQ_START(acq), .o_DLCNT_START_n(dl_n), .o_SUPBDLCNTR_CNT(cnt),
        .o_SUPBD_END_n(end_n), .o_Z14_ERR_n(err_n), .o_LOCKED(locked),
        .o_LOCK_FAIL(fail), .o_RETRY_CNT(retry), .o_WDT_TRIP(wdt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; pcen_n = 1'b1; req = 1'b0; rot_n0 = 1'b1;
        valid = 1'b0; z14_n = 1'b1; tmo_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One enabled edge followed by 0..2 disabled clocks; outputs must hold across the gap.
    task automatic tick_go();
        int gap;
        pcen_n = 1'b0;
        @(posedge clk);
        #1 pcen_n = 1'b1;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_trace(input int n);
        logic c;
        for (int t = 0; t < n; t++) begin
            req = s_req[t]; rot_n0 = s_rot[t]; valid = s_valid[t];
            z14_n = s_z14[t]; tmo_n = s_tmo[t];
            #1 c = cnt;
            tick_go();
            obs[t] = {acq, dl_n, c, end_n, err_n, locked, fail, retry, wdt};
        end
    endtask

    task automatic gen_random(input int n, input int drop_pct, input int tmo_pct, input int z14_pct);
        int hold = 0;
        for (int i = 0; i < n; i++) begin
            if (hold == 0 && $urandom_range(0, 99) < drop_pct) hold = $urandom_range(1, 3);
            s_req[i] = (hold == 0);
            if (hold > 0) hold--;
            s_rot[i]   = ($urandom_range(0, 3) != 0);
            s_valid[i] = ($urandom_range(0, 2) != 0) || (i % 8 == 0);
            s_z14[i]   = ($urandom_range(0, 99) < z14_pct);
            s_tmo[i]   = !($urandom_range(0, 99) < tmo_pct);
        end
    endtask

    // Walks the stimulus phase by phase (idle wait, slot-0 search, bit count, check) and marks expected events.
    function automatic void build_model(input int n);
        int t = 0, r = 0, a, s, c, u, k;
        bit to_idle, ab;
        for (int i = 0; i < n; i++) begin
            e_acq[i] = 0; e_dl[i] = 1; e_cnt[i] = 0; e_end[i] = 1; e_err[i] = 1;
            e_lock[i] = 0; e_fail[i] = 0; e_retry[i] = 0;
        end
        while (t < n) begin
            if (!s_req[t]) begin t++; continue; end
            t++; r = 0; to_idle = 0;
            while (!to_idle && t < n) begin
                a = t;
                while (a < n && s_req[a] && s_rot[a]) begin e_retry[a] = r; a++; end
                if (a >= n) begin t = n; break; end
                if (!s_req[a]) begin t = a + 1; to_idle = 1; break; end
                e_retry[a] = r; e_acq[a] = 1; e_dl[a] = 0;
                k = 0; s = a + 1; ab = 0;
                while (s < n) begin
                    e_cnt[s] = s_valid[s];
                    if (!s_req[s]) begin ab = 1; break; end
                    e_retry[s] = r;
                    if (s_valid[s]) k++;
                    if (k == LB) break;
                    s++;
                end
                if (s >= n) begin t = n; break; end
                if (ab) begin t = s + 1; to_idle = 1; break; end
                e_end[s] = 0;
                if (s + 2 >= n) begin t = n; break; end
                if (!s_req[s + 1]) begin t = s + 2; to_idle = 1; break; end
                e_retry[s + 1] = r;
                c = s + 2;
                if (!s_req[c]) begin t = c + 1; to_idle = 1; break; end
                if (!s_z14[c]) begin
                    e_lock[c] = 1; e_retry[c] = r; u = c + 1;
                    while (u < n && s_req[u] && s_tmo[u]) begin e_lock[u] = 1; e_retry[u] = r; u++; end
                    if (u < n) e_err[u] = 0;
                    t = u + 1; to_idle = 1;
                end else begin
                    r = (r < 3) ? r + 1 : 3;
                    e_retry[c] = r;
                    if (r == MAXR) begin
                        e_err[c] = 0; e_fail[c] = 1; u = c + 1;
                        while (u < n && s_req[u]) begin e_fail[u] = 1; e_retry[u] = r; u++; end
                        t = u + 1; to_idle = 1;
                    end else begin
                        t = c + 1;
                    end
                end
            end
        end
    endfunction

    task automatic compare_trace(input string name, input int n);
        logic [9:0] ex;
        build_model(n);
        for (int t = 0; t < n; t++) begin
            ex = {e_acq[t], e_dl[t], e_cnt[t], e_end[t], e_err[t], e_lock[t], e_fail[t],
                  2'(e_retry[t]), 1'b0};
            checks++;
            if (obs[t] !== ex) begin
                errors++;
                $display("[TB] FAIL %s tick %0d: got %b want %b (acq,dl_n,cnt,end_n,err_n,lock,fail,retry,wdt)",
                         name, t, obs[t], ex);
            end
        end
    endtask

    function automatic void clear_stim(input int n);
        for (int i = 0; i < n; i++) begin
            s_req[i] = 1; s_rot[i] = 1; s_valid[i] = 0; s_z14[i] = 1; s_tmo[i] = 1;
        end
    endfunction

    task automatic test_reset();
        logic [9:0] v;
        do_reset();
        #1 v = {acq, dl_n, cnt, end_n, err_n, locked, fail, retry, wdt};
        checks++;
        if (v !== RST_VEC) begin
            errors++; $display("[TB] FAIL reset_values: got %b want %b", v, RST_VEC);
        end
        clear_stim(6);
        s_rot[1] = 0;
        for (int i = 2; i < 6; i++) s_valid[i] = 1;
        run_trace(6);
        valid = 1'b1; rst = 1'b1; pcen_n = 1'b1;
        @(posedge clk);
        #1 v = {acq, dl_n, cnt, end_n, err_n, locked, fail, retry, wdt};
        checks++;
        if (v !== RST_VEC) begin
            errors++; $display("[TB] FAIL reset_mid_shift: got %b want %b", v, RST_VEC);
        end
        rst = 1'b0;
        clear_stim(16);
        s_rot[1] = 0; s_z14[11] = 0;
        for (int i = 2; i < 16; i++) s_valid[i] = 1;
        run_trace(16);
        compare_trace("post_reset_lock", 16);
    endtask

    task automatic test_lock_spec();
        int strobes = 0;
        do_reset();
        clear_stim(20);
        s_rot[5] = 0; s_z14[15] = 0;
        for (int i = 6; i < 14; i++) s_valid[i] = 1;
        run_trace(20);
        compare_trace("lock_spec", 20);
        for (int i = 0; i < 20; i++) strobes += int'(obs[i][7]);
        checks++;
        if (strobes != 8) begin errors++; $display("[TB] FAIL cnt_strobes: got %0d want 8", strobes); end
        checks++;
        if (obs[5][9:8] !== 2'b10) begin errors++; $display("[TB] FAIL acq_pulse_tick5: got %b want 10", obs[5][9:8]); end
        checks++;
        if (obs[13][6] !== 1'b0 || obs[14][6] !== 1'b1) begin
            errors++; $display("[TB] FAIL end_pulse: got %b%b want 01", obs[13][6], obs[14][6]);
        end
        checks++;
        if (obs[14][4] !== 1'b0 || obs[15][4] !== 1'b1) begin
            errors++; $display("[TB] FAIL locked_timing: got %b%b want 01", obs[14][4], obs[15][4]);
        end
    endtask

    task automatic test_retry_fail();
        int errp = 0, first_fail = -1;
        bit saw1 = 0, saw2 = 0;
        do_reset();
        gen_random(110, 0, 0, 100);
        for (int i = 0; i < 110; i++) begin
            s_rot[i] = (i % 4 != 0);
            s_req[i] = (i < 100);
        end
        run_trace(110);
        compare_trace("retry_fail", 110);
        for (int i = 0; i < 100; i++) begin
            if (obs[i][5] === 1'b0) errp++;
            if (obs[i][2:1] == 2'd1) saw1 = 1;
            if (obs[i][2:1] == 2'd2) saw2 = 1;
            if (first_fail < 0 && obs[i][3] === 1'b1) first_fail = i;
        end
        checks++;
        if (errp != 1) begin errors++; $display("[TB] FAIL err_pulse_count: got %0d want 1", errp); end
        checks++;
        if (!(saw1 && saw2) || first_fail < 0 || obs[first_fail][2:1] !== 2'd3) begin
            errors++;
            $display("[TB] FAIL retry_sequence: got saw1=%0d saw2=%0d fail_tick=%0d want 1,1,retry3 at fail",
                     saw1, saw2, first_fail);
        end
        checks++;
        if (obs[101][3] !== 1'b0 || obs[101][2:1] !== 2'd0) begin
            errors++; $display("[TB] FAIL fail_release: got %b want fail=0 retry=00", obs[101][3:1]);
        end
    endtask

    task automatic test_timeover();
        do_reset();
        clear_stim(20);
        s_rot[1] = 0; s_z14[11] = 0; s_tmo[14] = 0;
        for (int i = 2; i < 10; i++) s_valid[i] = 1;
        for (int i = 15; i < 20; i++) s_req[i] = 0;
        run_trace(20);
        compare_trace("timeover", 20);
        checks++;
        if (obs[13][4] !== 1'b1 || obs[14][5:4] !== 2'b00 || obs[15][5] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeover_drop: got lock13=%b err14=%b lock14=%b err15=%b want 1,0,0,1",
                     obs[13][4], obs[14][5], obs[14][4], obs[15][5]);
        end
    endtask

    task automatic test_abort();
        int ends = 0, cnts = 0;
        do_reset();
        clear_stim(40);
        s_rot[1] = 0;
        for (int i = 2; i < 40; i++) s_valid[i] = 1;
        for (int i = 5; i < 11; i++) s_req[i] = 0;
        s_rot[13] = 0; s_z14[24] = 0;
        run_trace(40);
        compare_trace("abort", 40);
        for (int i = 0; i < 11; i++) ends += int'(!obs[i][6]);
        for (int i = 6; i < 11; i++) cnts += int'(obs[i][7]);
        checks++;
        if (ends != 0 || cnts != 0) begin
            errors++; $display("[TB] FAIL abort_quiet: got ends=%0d cnts=%0d want 0,0", ends, cnts);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            do_reset();
            gen_random(200, 3, 10, 50);
            run_trace(200);
            compare_trace($sformatf("random%0d", it), 200);
        end
    endtask

`ifdef K005297_Z14SEQ_WDT_EN
    task automatic test_watchdog();
        do_reset();
        clear_stim(24);
        s_rot[1] = 0;
        run_trace(24);
        checks++;
        if (obs[16][3] !== 1'b0 || obs[16][0] !== 1'b0) begin
            errors++; $display("[TB] FAIL wdt_early: got fail=%b trip=%b want 0,0", obs[16][3], obs[16][0]);
        end
        checks++;
        if (obs[17][0] !== 1'b1 || obs[17][5] !== 1'b0 || obs[17][3] !== 1'b1 || obs[18][5] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wdt_trip: got trip=%b err=%b fail=%b err_next=%b want 1,0,1,1",
                     obs[17][0], obs[17][5], obs[17][3], obs[18][5]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock_spec();
        test_retry_fail();
        test_timeover();
        test_abort();
        test_random();
`ifdef K005297_Z14SEQ_WDT_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
